rr_grant_controller: RTL
========================

// Module: rr_grant_controller
// PURPOSE
//  Round-robin arbiter sharing one resource among 4 requesters. Grant is one-hot,
//  produced by the team's enable-gated 2-to-4 decoder driven from the registered
//  winner index. Each owner's tenure is bounded by MAX_HOLD cycles. Sits between
//  requester blocks and the shared datapath/bus select.
// PARAMETERS
//  MAX_HOLD   8   max consecutive cycles one owner may hold grant; legal range >= 1
// PORTS
//  clk          in   1  single clock, all state updates on rising edge
//  rst          in   1  synchronous, active-high reset
//  req          in   4  request per requester; bit i = requester i
//  gnt          out  4  one-hot grant = decode(gnt_idx) enabled by gnt_valid; 0 when idle
//  gnt_idx      out  2  binary index of current owner
//  gnt_valid    out  1  high while a grant is active
//  hold_expired out  1  1-cycle pulse: owner lost grant by hitting MAX_HOLD
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, gnt=4'b0000, gnt_idx=0, gnt_valid=0,
//   hold_expired=0, ptr=0 (priority order 0,1,2,3), hold_cnt=0. rst overrides all.
//  Reset mid-grant: gnt is 0 from the edge where rst is sampled; no expire pulse.
//  ptr: rotating priority pointer; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
//  States:
//   IDLE : if |req -> GRANT, gnt_idx<=winner, hold_cnt<=1. Else stay.
//          Latency: req sampled at edge N -> gnt visible after edge N (1 cycle).
//   GRANT: gnt=one-hot(gnt_idx), gnt_valid=1. At each edge:
//    - release if req[gnt_idx]==0 (voluntary) or hold_cnt==MAX_HOLD (expiry).
//    - on release: ptr<=gnt_idx+1 (mod 4); re-arbitrate same edge over req with
//      new ptr; winner -> stay GRANT, gnt_idx<=winner, hold_cnt<=1 (back-to-back,
//      no idle bubble); no req -> IDLE, gnt<=0.
//    - on expiry: hold_expired<=1 for one cycle; expired owner is lowest priority
//      and is re-granted only if it is the sole requester (hold_cnt restarts at 1).
//    - no release: hold_cnt<=hold_cnt+1, gnt unchanged.
//  Voluntary release and expiry on same edge: treated as voluntary, no pulse.
//  req changes of non-owners never preempt current owner.
//  gnt never has >1 bit set; gnt==0 iff gnt_valid==0.
//  hold_cnt width = $clog2(MAX_HOLD+1); never exceeds MAX_HOLD; no wrap.
//  ptr wraps 3->0.
// STRUCTURE
//  Shared package: state encoding (IDLE, GRANT), NUM_REQ=4, IDX_W=2.
//  Sub-module: grant_decoder (2-to-4, enable input; enable=gnt_valid).
//  Rotating-priority pick is combinational logic in this module.
// TESTING
//  1 rst held 2 cycles, req=4'b1111 -> gnt=0, gnt_valid=0 throughout reset.
//  2 after reset req=4'b1111, each owner drops req after 1 grant cycle ->
//    gnt sequence 0001,0010,0100,1000, no idle cycles between.
//  3 req=4'b0100 held, MAX_HOLD=8 -> gnt=0100 for 8 cycles, hold_expired pulse,
//    re-granted to 2 (sole requester), hold_cnt restarts.
//  4 req=4'b0101 held, MAX_HOLD=8 -> 0001 for 8 cycles, expire, 0100 for 8,
//    expire, 0001 ...
//  5 rst asserted while gnt=0010 -> gnt=0 next edge, after release req=4'b0010
//    -> grant to 1 again (ptr=0 order).
//  6 MAX_HOLD=1, req=4'b1111 -> gnt rotates every cycle, hold_expired high each cycle.

Source files
------------

// File: rtl/rr_grant_controller_pkg.sv
// Shared definitions for the round-robin grant controller: state encoding,
// requester count, index width and a wrapping index increment helper.
package rr_grant_controller_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Next requester index in ring order; IDX_W bits wrap 3 -> 0 naturally.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
        return idx + {{(IDX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage : rr_grant_controller_pkg

// File: rtl/rr_grant_controller_grant_decoder.sv
// Enable-gated 2-to-4 decoder turning the registered owner index into the
// one-hot grant vector. Output is all zeros while the enable is low.
module grant_decoder
    import rr_grant_controller_pkg::*;
(
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] dec_o
);

    // One-hot decode of idx_i, forced to zero when not enabled.
    always_comb begin
        dec_o = {NUM_REQ{1'b0}};
        if (en_i) begin
            dec_o[idx_i] = 1'b1;
        end else begin
            dec_o = {NUM_REQ{1'b0}};
        end
    end

endmodule : grant_decoder

// File: rtl/rr_grant_controller.sv
// Round-robin arbiter for four requesters sharing one resource. An owner keeps
// the grant until it drops its request or has held it for MAX_HOLD cycles; on
// release the next owner is chosen on the same edge so there is no idle bubble.
module rr_grant_controller
    import rr_grant_controller_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               hold_expired
);

    localparam int                CNT_W      = $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0]  MAX_HOLD_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);

    state_e             state_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic               gnt_valid_q;
    logic               hold_expired_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   hold_cnt_q;

    logic [IDX_W-1:0]   search_ptr_s;
    logic [IDX_W-1:0]   cand_s;
    logic               pick_found_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               voluntary_s;
    logic               expire_s;
    logic               release_s;
    logic               expire_pulse_s;

    // Release conditions of the current owner; voluntary release wins over expiry.
    always_comb begin
        voluntary_s    = 1'b0;
        expire_s       = 1'b0;
        release_s      = 1'b0;
        expire_pulse_s = 1'b0;
        if (state_q == ST_GRANT) begin
            voluntary_s    = ~req[gnt_idx_q];
            expire_s       = (hold_cnt_q == MAX_HOLD_C);
            release_s      = voluntary_s | expire_s;
            expire_pulse_s = expire_s & ~voluntary_s;
        end else begin
            voluntary_s    = 1'b0;
            expire_s       = 1'b0;
            release_s      = 1'b0;
            expire_pulse_s = 1'b0;
        end
    end

    // Search start: stored pointer when idle, owner+1 when re-arbitrating on
    // release, which also makes an expiring owner the lowest priority.
    always_comb begin
        if (state_q == ST_GRANT) begin
            search_ptr_s = idx_inc(gnt_idx_q);
        end else begin
            search_ptr_s = ptr_q;
        end
    end

    // Rotating-priority pick: scan from the farthest offset down so the
    // closest requesting index to search_ptr_s is the one left standing.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = {IDX_W{1'b0}};
        cand_s       = {IDX_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s = search_ptr_s + IDX_W'(i);
            if (req[cand_s]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_s;
            end else begin
                pick_found_s = pick_found_s;
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Arbitration FSM with registered grant index, valid, expiry pulse,
    // rotating pointer and tenure counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            gnt_idx_q      <= {IDX_W{1'b0}};
            gnt_valid_q    <= 1'b0;
            hold_expired_q <= 1'b0;
            ptr_q          <= {IDX_W{1'b0}};
            hold_cnt_q     <= CNT_ZERO;
        end else begin
            hold_expired_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_q     <= ST_GRANT;
                        gnt_idx_q   <= pick_idx_s;
                        gnt_valid_q <= 1'b1;
                        hold_cnt_q  <= CNT_ONE;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        ptr_q          <= idx_inc(gnt_idx_q);
                        hold_expired_q <= expire_pulse_s;
                        if (pick_found_s) begin
                            gnt_idx_q   <= pick_idx_s;
                            gnt_valid_q <= 1'b1;
                            hold_cnt_q  <= CNT_ONE;
                        end else begin
                            state_q     <= ST_IDLE;
                            gnt_valid_q <= 1'b0;
                            hold_cnt_q  <= CNT_ZERO;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    gnt_valid_q    <= 1'b0;
                    hold_expired_q <= 1'b0;
                    hold_cnt_q     <= CNT_ZERO;
                end
            endcase
        end
    end

    grant_decoder u_grant_decoder (
        .idx_i (gnt_idx_q),
        .en_i  (gnt_valid_q),
        .dec_o (gnt)
    );

    assign gnt_idx      = gnt_idx_q;
    assign gnt_valid    = gnt_valid_q;
    assign hold_expired = hold_expired_q;

endmodule : rr_grant_controller
